// File: rtl/xbar_ingress_filter_if.sv
// AXI4-Stream beat bundle shared by the RX queue side and the crossbar side.
interface xbar_ingress_filter_if #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128
);
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                           tvalid;
    logic                           tready;
    logic                           tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/xbar_ingress_filter.sv
// Per-port ingress filter: forwards/drops whole packets on the tuser dst byte and stamps src.
// One cycle s->m latency via a 2-entry skid slice; s tready is registered, forced high while dropping.
module xbar_ingress_filter #(
    parameter int          C_AXIS_DATA_WIDTH  = 64,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  SRC_PORT_ID        = 8'h01,
    parameter logic [7:0]  DST_MASK           = 8'h1F
) (
    input  logic                           axis_aclk,
    input  logic                           axis_aresetn,
    xbar_ingress_filter_if.slave           s_axis,
    xbar_ingress_filter_if.master          m_axis,
    input  logic                           clear_counters,
    output logic [31:0]                    pkt_fwd_count,
    output logic [31:0]                    pkt_drop_count
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [C_AXIS_DATA_WIDTH-1:0]  dat;
        logic [KW-1:0]                 keep;
        logic [C_AXIS_TUSER_WIDTH-1:0] user;
        logic                          last;
    } beat_t;

    typedef enum logic [1:0] {ST_HEAD, ST_PASS, ST_DROP} state_t;

    state_t      state_q, state_d;
    logic        in_rdy_q, in_rdy_d;
    logic        out_vld_q, out_vld_d;
    logic        skid_vld_q, skid_vld_d;
    beat_t       out_q, out_d;
    beat_t       skid_q, skid_d;
    beat_t       in_beat;
    logic [15:0] stamp_q;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    logic [7:0]  dst_eff;
    logic        accept;
    logic        fwd;
    logic        pop;
    logic        fwd_last;
    logic        drop_last;

    assign dst_eff   = s_axis.tuser[31:24] & DST_MASK;
    assign accept    = s_axis.tvalid & in_rdy_q;
    assign fwd       = accept & (((state_q == ST_HEAD) && (dst_eff != 8'h00)) || (state_q == ST_PASS));
    assign pop       = out_vld_q & m_axis.tready;
    assign fwd_last  = fwd & s_axis.tlast;
    assign drop_last = accept & ~fwd & s_axis.tlast;

    always_comb begin
        in_beat = '{dat: s_axis.tdata, keep: s_axis.tkeep, user: s_axis.tuser, last: s_axis.tlast};
        // Body beats inherit the head beat's dst/src so the crossbar sees a consistent route.
        in_beat.user[31:16] = (state_q == ST_HEAD) ? {dst_eff, SRC_PORT_ID} : stamp_q;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_HEAD: begin
                    if (!s_axis.tlast) begin
                        state_d = (dst_eff != 8'h00) ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS, ST_DROP: begin
                    if (s_axis.tlast) begin
                        state_d = ST_HEAD;
                    end
                end
                default: state_d = ST_HEAD;
            endcase
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = fwd;
                if (fwd) begin
                    skid_d = in_beat;
                end
            end else begin
                out_vld_d = fwd;
                if (fwd) begin
                    out_d = in_beat;
                end
            end
        end else if (fwd) begin
            skid_vld_d = 1'b1;
            skid_d     = in_beat;
        end
        in_rdy_d = (state_d == ST_DROP) ? 1'b1 : !skid_vld_d;
    end

    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_counters) begin
            fwd_cnt_d  = 32'd0;
            drop_cnt_d = 32'd0;
        end else begin
            if (fwd_last && (fwd_cnt_q != CNT_MAX)) begin
                fwd_cnt_d = fwd_cnt_q + 32'd1;
            end
            if (drop_last && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= ST_HEAD;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            stamp_q    <= 16'h0000;
            fwd_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            in_rdy_q   <= in_rdy_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (accept && (state_q == ST_HEAD)) begin
                stamp_q <= {dst_eff, SRC_PORT_ID};
            end
        end
    end

    assign s_axis.tready  = in_rdy_q;
    assign m_axis.tvalid  = out_vld_q;
    assign m_axis.tdata   = out_q.dat;
    assign m_axis.tkeep   = out_q.keep;
    assign m_axis.tuser   = out_q.user;
    assign m_axis.tlast   = out_q.last;
    assign pkt_fwd_count  = fwd_cnt_q;
    assign pkt_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_xbar_ingress_filter.sv
// Bench for xbar_ingress_filter: packet table plus hand-written stall, reset and counter sequences.
module tb_xbar_ingress_filter;

    localparam int DW = 64;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] fwd_cnt;
    logic [31:0] drop_cnt;

    always #5 clk = ~clk;

    xbar_ingress_filter_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) s_if ();
    xbar_ingress_filter_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) m_if ();

    xbar_ingress_filter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .SRC_PORT_ID       (8'h01),
        .DST_MASK          (8'h1F)
    ) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .clear_counters(clr),
        .pkt_fwd_count (fwd_cnt),
        .pkt_drop_count(drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] dat;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            cyc;
    } exp_t;

    typedef struct {
        int         beats;
        logic [7:0] dst;
        bit         fwd;
        logic [7:0] exp_dst;
        int         exp_fwd_cnt;
        int         exp_drop_cnt;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;

    logic          stall_q = 1'b0;
    logic [DW-1:0] hold_dat;
    logic [UW-1:0] hold_user;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_vld", UW'(m_if.tvalid), UW'(1));
                chk("hold_dat", UW'(m_if.tdata), UW'(hold_dat));
                chk("hold_user", m_if.tuser, hold_user);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h expected no beat", m_if.tdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_dat", UW'(m_if.tdata), UW'(mon_e.dat));
                    chk("out_keep", UW'(m_if.tkeep), UW'(mon_e.keep));
                    chk("out_user", m_if.tuser, mon_e.user);
                    chk("out_last", UW'(m_if.tlast), UW'(mon_e.last));
                    if (lat_chk) chk("latency", UW'(cyc - mon_e.cyc), UW'(1));
                end
            end
            stall_q   = m_if.tvalid && !m_if.tready;
            hold_dat  = m_if.tdata;
            hold_user = m_if.tuser;
        end
    end

    // Drives one beat from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic send_beat(input logic [UW-1:0] user, input logic last, input bit exp_fwd,
                             input logic [7:0] exp_dst, output int waited);
        exp_t          e;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        d = {$urandom, $urandom};
        k = KW'($urandom);
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tuser  = user;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_if.tready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got tready 0 for %0d cycles expected acceptance", waited);
        end else if (exp_fwd) begin
            e.dat  = d;
            e.keep = k;
            e.user = user;
            e.user[31:16] = {exp_dst, 8'h01};
            e.last = last;
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v, output int waits);
        logic [UW-1:0] user;
        int w;
        waits = 0;
        for (int b = 0; b < v.beats; b++) begin
            user = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) user[31:24] = v.dst;
            send_beat(user, b == v.beats - 1, v.fwd, v.exp_dst, w);
            waits += w;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", UW'(sb.size()), UW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   w;

        vecs[0] = '{4, 8'h04, 1'b1, 8'h04, 1, 0};
        vecs[1] = '{3, 8'hE0, 1'b0, 8'h00, 1, 1};
        vecs[2] = '{2, 8'h02, 1'b1, 8'h02, 2, 1};
        vecs[3] = '{1, 8'h08, 1'b1, 8'h08, 3, 1};
        vecs[4] = '{2, 8'h3F, 1'b1, 8'h1F, 4, 1};
        vecs[5] = '{1, 8'h20, 1'b0, 8'h00, 4, 2};
        vecs[6] = '{3, 8'h81, 1'b1, 8'h01, 5, 2};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_vld", UW'(m_if.tvalid), UW'(0));
        chk("rst_m_dat", UW'(m_if.tdata), UW'(0));
        chk("rst_m_user", m_if.tuser, UW'(0));
        chk("rst_m_keep_last", UW'({m_if.tkeep, m_if.tlast}), UW'(0));
        chk("rst_s_rdy", UW'(s_if.tready), UW'(0));
        chk("rst_fwd_cnt", UW'(fwd_cnt), UW'(0));
        chk("rst_drop_cnt", UW'(drop_cnt), UW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", UW'(s_if.tready), UW'(1));

        // Back-to-back packet table with an always-ready crossbar.
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_pkt(vecs[i], w);
            if (!vecs[i].fwd) chk("drop_no_stall", UW'(w), UW'(0));
            chk("tbl_fwd_cnt", UW'(fwd_cnt), UW'(vecs[i].exp_fwd_cnt));
            chk("tbl_drop_cnt", UW'(drop_cnt), UW'(vecs[i].exp_drop_cnt));
        end
        drain();
        lat_chk = 1'b0;

        // Crossbar stall fills the skid; tready must fall after two buffered beats.
        v = '{6, 8'h11, 1'b1, 8'h11, 6, 2};
        fork
            send_pkt(v, w);
            begin
                @(posedge clk);
                #1;
                m_if.tready = 1'b0;
                @(negedge clk);
                chk("stall_rdy_one_buf", UW'(s_if.tready), UW'(1));
                @(negedge clk);
                chk("stall_rdy_full", UW'(s_if.tready), UW'(0));
                chk("stall_m_vld", UW'(m_if.tvalid), UW'(1));
                repeat (3) @(posedge clk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        drain();
        chk("stall_fwd_cnt", UW'(fwd_cnt), UW'(v.exp_fwd_cnt));
        chk("stall_drop_cnt", UW'(drop_cnt), UW'(v.exp_drop_cnt));

        // Reset in the middle of a forwarded packet.
        send_beat({$urandom, $urandom, $urandom, 8'h04, 24'h00_0040}, 1'b0, 1'b1, 8'h04, w);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 8'h04, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_vld", UW'(m_if.tvalid), UW'(0));
        chk("midrst_s_rdy", UW'(s_if.tready), UW'(0));
        chk("midrst_fwd_cnt", UW'(fwd_cnt), UW'(0));
        chk("midrst_drop_cnt", UW'(drop_cnt), UW'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rdy_back", UW'(s_if.tready), UW'(1));
        v = '{2, 8'h02, 1'b1, 8'h02, 1, 0};
        send_pkt(v, w);
        drain();
        chk("postrst_fwd_cnt", UW'(fwd_cnt), UW'(1));
        chk("postrst_drop_cnt", UW'(drop_cnt), UW'(0));

        // Drop counter saturation from a preloaded near-max value.
        force dut.drop_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.drop_cnt_q;
        v = '{1, 8'hE0, 1'b0, 8'h00, 1, 0};
        send_pkt(v, w);
        chk("sat_reach_max", UW'(drop_cnt), UW'(32'hFFFF_FFFF));
        send_pkt(v, w);
        chk("sat_hold_max", UW'(drop_cnt), UW'(32'hFFFF_FFFF));
        chk("sat_fwd_cnt", UW'(fwd_cnt), UW'(1));

        // Clear coincident with a dropped tlast wins.
        clr = 1'b1;
        send_pkt(v, w);
        clr = 1'b0;
        chk("clr_accept_now", UW'(w), UW'(0));
        chk("clr_drop_cnt", UW'(drop_cnt), UW'(0));
        chk("clr_fwd_cnt", UW'(fwd_cnt), UW'(0));

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
